// File: rtl/mem_port_ctrl.sv
// Per-core load/store sequencer between a 16-bit core handshake and one port of
// the shared byte-wide data memory (registered read port, two-byte write port).
module mem_port_ctrl #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req,
  input  logic                    wr,
  input  logic                    byte_en,
  input  logic [ADDR_WIDTH-1:0]   addr,
  input  logic [2*DATA_WIDTH-1:0] wdata,
  output logic                    ready,
  output logic                    done,
  output logic [2*DATA_WIDTH-1:0] rdata,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_w_addr,
  output logic [2*DATA_WIDTH-1:0] mem_w_data,
  output logic [ADDR_WIDTH-1:0]   mem_r_addr,
  input  logic [DATA_WIDTH-1:0]   mem_r_data
);

  localparam int unsigned WW = 2 * DATA_WIDTH;

  typedef enum logic [2:0] {
    IDLE, RD_LO, RD_HI, RD_CAP, RMW_RD, RMW_CAP, WR, DONE
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] a_q, a_d;
  logic                  b_q, b_d;
  logic [WW-1:0]         d_q, d_d;
  logic [DATA_WIDTH-1:0] h_q, h_d;
  logic                  ready_q, ready_d;
  logic                  done_q, done_d;
  logic [WW-1:0]         rdata_q, rdata_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_w_addr_q, mem_w_addr_d;
  logic [WW-1:0]         mem_w_data_q, mem_w_data_d;
  logic [ADDR_WIDTH-1:0] mem_r_addr_q, mem_r_addr_d;

  // State and registered outputs; reset also kills an in-flight write enable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      a_q          <= '0;
      b_q          <= 1'b0;
      d_q          <= '0;
      h_q          <= '0;
      ready_q      <= 1'b1;
      done_q       <= 1'b0;
      rdata_q      <= '0;
      mem_we_q     <= 1'b0;
      mem_w_addr_q <= '0;
      mem_w_data_q <= '0;
      mem_r_addr_q <= '0;
    end else begin
      state_q      <= state_d;
      a_q          <= a_d;
      b_q          <= b_d;
      d_q          <= d_d;
      h_q          <= h_d;
      ready_q      <= ready_d;
      done_q       <= done_d;
      rdata_q      <= rdata_d;
      mem_we_q     <= mem_we_d;
      mem_w_addr_q <= mem_w_addr_d;
      mem_w_data_q <= mem_w_data_d;
      mem_r_addr_q <= mem_r_addr_d;
    end
  end

  // Outputs are computed for the state being entered so they are valid in it.
  always_comb begin
    state_d      = state_q;
    a_d          = a_q;
    b_d          = b_q;
    d_d          = d_q;
    h_d          = h_q;
    rdata_d      = rdata_q;
    mem_we_d     = 1'b0;
    mem_w_addr_d = mem_w_addr_q;
    mem_w_data_d = mem_w_data_q;
    mem_r_addr_d = mem_r_addr_q;

    case (state_q)
      IDLE: begin
        if (req) begin
          a_d = addr;
          b_d = byte_en;
          d_d = wdata;
          if (!wr) begin
            state_d      = RD_LO;
            mem_r_addr_d = addr;
          end else if (byte_en) begin
            state_d      = RMW_RD;
            mem_r_addr_d = addr + ADDR_WIDTH'(1);
          end else begin
            state_d      = WR;
            mem_we_d     = 1'b1;
            mem_w_addr_d = addr;
            mem_w_data_d = wdata;
          end
        end
      end
      RD_LO: begin
        state_d      = RD_HI;
        mem_r_addr_d = a_q + ADDR_WIDTH'(1);
      end
      RD_HI: begin
        rdata_d[DATA_WIDTH-1:0] = mem_r_data;
        if (b_q) begin
          rdata_d[WW-1:DATA_WIDTH] = '0;
          state_d                  = DONE;
        end else begin
          state_d = RD_CAP;
        end
      end
      RD_CAP: begin
        rdata_d[WW-1:DATA_WIDTH] = mem_r_data;
        state_d                  = DONE;
      end
      RMW_RD: begin
        state_d = RMW_CAP;
      end
      RMW_CAP: begin
        // Merge the freshly read neighbour byte straight into the write word.
        h_d          = mem_r_data;
        state_d      = WR;
        mem_we_d     = 1'b1;
        mem_w_addr_d = a_q;
        mem_w_data_d = {mem_r_data, d_q[DATA_WIDTH-1:0]};
      end
      WR: begin
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign ready_d    = (state_d == IDLE);
  assign done_d     = (state_d == DONE);

  assign ready      = ready_q;
  assign done       = done_q;
  assign rdata      = rdata_q;
  assign mem_we     = mem_we_q;
  assign mem_w_addr = mem_w_addr_q;
  assign mem_w_data = mem_w_data_q;
  assign mem_r_addr = mem_r_addr_q;

endmodule

// File: tb/tb_mem_port_ctrl.sv
// Bench for mem_port_ctrl: byte-array memory reference, directed scenarios
// followed by random loads/stores, all compared with immediate assertions.
module tb_mem_port_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic        wr = 1'b0;
  logic        byte_en = 1'b0;
  logic [7:0]  addr = '0;
  logic [15:0] wdata = '0;
  logic        ready, done, mem_we;
  logic [15:0] rdata, mem_w_data;
  logic [7:0]  mem_w_addr, mem_r_addr;
  logic [7:0]  mem_r_data = '0;

  logic [7:0]  mem [256];
  logic [7:0]  ref_mem [256];
  logic        pl_en = 1'b0;
  logic [7:0]  pl_addr = '0;
  logic [7:0]  pl_data = '0;

  int passed = 0;
  int total = 0;
  int both_hi = 0;

  always #5 clk = ~clk;

  mem_port_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .req(req), .wr(wr), .byte_en(byte_en),
    .addr(addr), .wdata(wdata), .ready(ready), .done(done), .rdata(rdata),
    .mem_we(mem_we), .mem_w_addr(mem_w_addr), .mem_w_data(mem_w_data),
    .mem_r_addr(mem_r_addr), .mem_r_data(mem_r_data)
  );

  // Shared data memory port: two-byte write, registered byte read.
  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (mem_we) begin
      mem[mem_w_addr]               <= mem_w_data[7:0];
      mem[8'(mem_w_addr + 8'd1)]    <= mem_w_data[15:8];
    end
    if (!mem_we) mem_r_data <= mem[mem_r_addr];
  end

  always @(negedge clk) if (ready && done) both_hi <= both_hi + 1;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic preload(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    pl_addr = a; pl_data = d; pl_en = 1'b1;
    @(posedge clk);
    #1 pl_en = 1'b0;
    ref_mem[a] = d;
  endtask

  // One transaction; returns load data, write data and first two read addresses.
  task automatic txn(input logic w, input logic b, input logic [7:0] a,
                     input logic [15:0] d, input bit hold,
                     output logic [15:0] r_out, output logic [15:0] wd_out,
                     output logic [7:0] ra0, output logic [7:0] ra1);
    int cyc, we_cnt, exp_lat;
    logic [7:0]  wa, a1;
    logic [15:0] wd, exp_v;
    a1 = 8'(a + 8'd1);
    cyc = 0; we_cnt = 0; wa = '0; wd = '0; ra0 = '0; ra1 = '0;
    @(negedge clk);
    for (int k = 0; k < 20 && !ready; k++) @(negedge clk);
    check("ready_before_req", 16'(ready), 16'd1);
    req = 1'b1; wr = w; byte_en = b; addr = a; wdata = d;
    @(posedge clk);
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (i == 1) begin
        req = hold;
        wr = 1'($urandom); byte_en = 1'($urandom);
        addr = 8'($urandom); wdata = 16'($urandom);
        ra0 = mem_r_addr;
        check("busy_not_ready", 16'(ready), 16'd0);
      end
      if (i == 2) ra1 = mem_r_addr;
      if (mem_we) begin we_cnt++; wa = mem_w_addr; wd = mem_w_data; end
      if (done) begin cyc = i; break; end
    end
    req = 1'b0;
    exp_lat = w ? (b ? 4 : 2) : (b ? 3 : 4);
    check("latency", 16'(cyc), 16'(exp_lat));
    check("ready_low_in_done", 16'(ready), 16'd0);
    r_out = rdata; wd_out = wd;
    if (!w) begin
      exp_v = b ? {8'h00, ref_mem[a]} : {ref_mem[a1], ref_mem[a]};
      check("load_rdata", rdata, exp_v);
      check("load_no_write", 16'(we_cnt), 16'd0);
    end else begin
      exp_v = b ? {ref_mem[a1], d[7:0]} : d;
      check("store_we_count", 16'(we_cnt), 16'd1);
      check("store_w_addr", 16'(wa), 16'(a));
      check("store_w_data", wd, exp_v);
      ref_mem[a] = exp_v[7:0];
      ref_mem[a1] = exp_v[15:8];
    end
    @(negedge clk);
    check("ready_after_done", 16'(ready), 16'd1);
    check("done_one_cycle", 16'(done), 16'd0);
    if (!w) check("rdata_held", rdata, r_out);
    else begin
      check("mem_lo", 16'(mem[a]), 16'(ref_mem[a]));
      check("mem_hi", 16'(mem[a1]), 16'(ref_mem[a1]));
    end
  endtask

  initial begin
    logic [15:0] r, wdo;
    logic [7:0]  ra0, ra1;
    logic        w, b;

    @(negedge clk);
    check("rst_ready", 16'(ready), 16'd1);
    check("rst_done", 16'(done), 16'd0);
    check("rst_rdata", rdata, 16'h0000);
    check("rst_we", 16'(mem_we), 16'd0);
    check("rst_w_addr", 16'(mem_w_addr), 16'h0000);
    check("rst_w_data", mem_w_data, 16'h0000);
    check("rst_r_addr", 16'(mem_r_addr), 16'h0000);

    for (int i = 0; i < 256; i++) preload(8'(i), 8'($urandom));
    preload(8'h00, 8'h03);
    preload(8'h01, 8'h02);
    preload(8'h08, 8'h0A);
    @(negedge clk);
    rst = 1'b0;

    txn(1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, r, wdo, ra0, ra1);
    check("plan_ld16", r, 16'h0203);
    txn(1'b0, 1'b1, 8'h08, 16'h0000, 1'b0, r, wdo, ra0, ra1);
    check("plan_ld8", r, 16'h000A);
    txn(1'b1, 1'b0, 8'h40, 16'hBEEF, 1'b0, r, wdo, ra0, ra1);
    check("plan_st16_lo", 16'(mem[8'h40]), 16'h00EF);
    check("plan_st16_hi", 16'(mem[8'h41]), 16'h00BE);
    txn(1'b1, 1'b1, 8'h40, 16'h0012, 1'b0, r, wdo, ra0, ra1);
    check("plan_st8_wdata", wdo, 16'hBE12);
    txn(1'b0, 1'b0, 8'h40, 16'h0000, 1'b0, r, wdo, ra0, ra1);
    check("plan_st8_readback", r, 16'hBE12);

    for (int n = 0; n < 40; n++) begin
      w = 1'($urandom); b = 1'($urandom);
      txn(w, b, 8'($urandom), 16'($urandom), 1'b0, r, wdo, ra0, ra1);
    end

    preload(8'hFF, 8'h11);
    preload(8'h00, 8'h03);
    txn(1'b0, 1'b0, 8'hFF, 16'h0000, 1'b0, r, wdo, ra0, ra1);
    check("wrap_ra0", 16'(ra0), 16'h00FF);
    check("wrap_ra1", 16'(ra1), 16'h0000);
    check("wrap_rdata", r, 16'h0311);

    // Reset asserted inside the WR cycle of a 16-bit store.
    @(negedge clk);
    check("pre_rst_ready", 16'(ready), 16'd1);
    req = 1'b1; wr = 1'b1; byte_en = 1'b0; addr = 8'h20; wdata = 16'h5555;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    check("we_in_wr", 16'(mem_we), 16'd1);
    rst = 1'b1;
    #1;
    check("rst_drops_we", 16'(mem_we), 16'd0);
    @(negedge clk);
    rst = 1'b0;
    check("post_rst_ready", 16'(ready), 16'd1);
    check("post_rst_done", 16'(done), 16'd0);
    check("rst_wr_lo_kept", 16'(mem[8'h20]), 16'(ref_mem[8'h20]));
    check("rst_wr_hi_kept", 16'(mem[8'h21]), 16'(ref_mem[8'h21]));

    txn(1'b0, 1'b0, 8'h20, 16'h0000, 1'b1, r, wdo, ra0, ra1);
    @(negedge clk);
    check("held_req_ignored_ready", 16'(ready), 16'd1);
    check("held_req_ignored_done", 16'(done), 16'd0);

    check("ready_done_overlap", 16'(both_hi), 16'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
